// File: rtl/mesi_bus_pkg.sv
// Shared types for the two-core MESI coherence bus arbiter.
package mesi_bus_pkg;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_RDX  = 2'b01,
    BUS_UPGR = 2'b10,
    BUS_WB   = 2'b11
  } bus_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SNOOP = 2'b01,
    ST_MEM   = 2'b10,
    ST_DONE  = 2'b11
  } arb_state_t;

  localparam logic [1:0] GNT_NONE  = 2'b00;
  localparam logic [1:0] GNT_CORE0 = 2'b01;
  localparam logic [1:0] GNT_CORE1 = 2'b10;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? GNT_CORE1 : GNT_CORE0;
  endfunction

endpackage

// File: rtl/mesi_bus_arbiter_rr_pick2.sv
// Two-requester round-robin picker: a lone request wins outright, a tie goes to ptr.
module rr_pick2
  import mesi_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    if (req == 2'b11) win = owner_onehot(ptr);
  end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// Coherence bus arbiter for two L1 controllers: grant, snoop window, memory access,
// completion pulse. Exposes the FSM state on dbg_state.
module mesi_bus_arbiter
  import mesi_bus_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 32,
  parameter int SNOOP_LAT = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  bus_cmd_t          cmd0,
  input  bus_cmd_t          cmd1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              bus_valid,
  output bus_cmd_t          bus_cmd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_owner,
  input  logic              snoop_flush,
  input  logic [DATA_W-1:0] snoop_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output arb_state_t        dbg_state
);

  // Handshakes: req[i] is held until done[i] pulses for one cycle (rdata valid with it);
  // mem_req holds mem_we/mem_addr/mem_wdata constant until mem_ready, which completes
  // the access in that same cycle. A timeout abort drops mem_req without mem_ready.

  localparam int SC_W = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT) : 1;
  localparam int TC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t        state, state_nxt;
  logic [1:0]        win;
  logic              rr_ptr;
  logic              owner_q;
  logic [1:0]        gnt_q;
  bus_cmd_t          cmd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [SC_W-1:0]   scnt;
  logic [TC_W-1:0]   tcnt;
  logic              snoop_last;
  logic              mem_timeout;

  rr_pick2 u_pick (
    .req (req),
    .ptr (rr_ptr),
    .win (win)
  );

  assign snoop_last  = (state == ST_SNOOP) && (scnt == SC_W'(SNOOP_LAT - 1));
  assign mem_timeout = (state == ST_MEM) && !mem_ready && (tcnt == TC_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|req) state_nxt = ST_SNOOP;
      ST_SNOOP: if (snoop_last) state_nxt = (cmd_q == BUS_UPGR) ? ST_DONE : ST_MEM;
      ST_MEM:   if (mem_ready || mem_timeout) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr      <= 1'b0;
      owner_q     <= 1'b0;
      gnt_q       <= GNT_NONE;
      cmd_q       <= BUS_RD;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      scnt        <= '0;
      tcnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: if (|req) begin
          gnt_q   <= win;
          owner_q <= win[1];
          cmd_q   <= win[1] ? cmd1 : cmd0;
          addr_q  <= win[1] ? addr1 : addr0;
          wdata_q <= win[1] ? wdata1 : wdata0;
          rdata_q <= '0;
          scnt    <= '0;
          tcnt    <= '0;
        end
        ST_SNOOP: begin
          scnt <= scnt + 1'b1;
          if (snoop_last) begin
            case (cmd_q)
              BUS_RD, BUS_RDX: begin
                // A Modified copy elsewhere is both the answer and a line to write back.
                mem_we_q    <= snoop_flush;
                mem_wdata_q <= snoop_flush ? snoop_data : '0;
                if (snoop_flush) rdata_q <= snoop_data;
              end
              BUS_WB: begin
                mem_we_q    <= 1'b1;
                mem_wdata_q <= wdata_q;
              end
              default: ;
            endcase
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (!mem_we_q) rdata_q <= mem_rdata;
          end else if (mem_timeout) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_DONE: begin
          rr_ptr <= ~owner_q;
          gnt_q  <= GNT_NONE;
        end
        default: ;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = (state == ST_DONE) ? owner_onehot(owner_q) : GNT_NONE;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign bus_valid = (state == ST_SNOOP);
  assign bus_cmd   = cmd_q;
  assign bus_addr  = addr_q;
  assign bus_owner = owner_q;
  assign mem_req   = (state == ST_MEM);
  assign mem_we    = mem_req & mem_we_q;
  assign mem_addr  = mem_req ? addr_q : '0;
  assign mem_wdata = mem_req ? mem_wdata_q : '0;
  assign dbg_state = state;

endmodule
